// File: rtl/difftest_commit_buffer.sv
// Commit capture FIFO for the difftest top: packs up to NUM_CH retire records per cycle
// and drains one per cycle. Optional halt-trap detection is built when DIFFTEST_TRAP_EN is defined.
module difftest_commit_buffer #(
    parameter int NUM_CH  = 2,
    parameter int DEPTH   = 8,
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32,
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter logic [INSTR_W-1:0] TRAP_INSTR = INSTR_W'(32'h8000_0000)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     commit_en_i,
    input  logic [NUM_CH-1:0]        commit_valid_i,
    input  logic [NUM_CH*PC_W-1:0]   commit_pc_i,
    input  logic [NUM_CH*INSTR_W-1:0] commit_instr_i,
    input  logic [NUM_CH-1:0]        commit_wreg_i,
    input  logic [NUM_CH*REG_AW-1:0] commit_waddr_i,
    input  logic [NUM_CH*DATA_W-1:0] commit_wdata_i,
    output logic                     full_o,
    output logic                     overflow_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [PC_W-1:0]          out_pc_o,
    output logic [INSTR_W-1:0]       out_instr_o,
    output logic [REG_AW-1:0]        out_wdest_o,
    output logic [DATA_W-1:0]        out_wdata_o,
    output logic                     out_wen_o,
    output logic [7:0]               out_index_o,
    output logic [63:0]              cycle_cnt_o,
    output logic [63:0]              instr_cnt_o
`ifdef DIFFTEST_TRAP_EN
    ,
    output logic                     trap_valid_o,
    output logic [7:0]               trap_code_o,
    output logic [PC_W-1:0]          trap_pc_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]    mem_pc_q    [DEPTH];
    logic [INSTR_W-1:0] mem_instr_q [DEPTH];
    logic               mem_wreg_q  [DEPTH];
    logic [REG_AW-1:0]  mem_waddr_q [DEPTH];
    logic [DATA_W-1:0]  mem_wdata_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [63:0]      cycle_cnt_q, cycle_cnt_d;
    logic [63:0]      instr_cnt_q, instr_cnt_d;

    logic [CNT_W-1:0] n_enq;
    logic [CNT_W-1:0] free_slots;
    logic [NUM_CH-1:0] we;
    logic [PTR_W-1:0] slot_idx [NUM_CH];
    logic             full;
    logic             accept;
    logic             halted;
    logic             head_valid;
    logic             pop;

`ifdef DIFFTEST_TRAP_EN
    logic             trap_valid_q, trap_valid_d;
    logic [7:0]       trap_code_q, trap_code_d;
    logic [PC_W-1:0]  trap_pc_q, trap_pc_d;

    assign halted       = trap_valid_q;
    assign trap_valid_o = trap_valid_q;
    assign trap_code_o  = trap_code_q;
    assign trap_pc_o    = trap_pc_q;
`else
    assign halted = 1'b0;
`endif

    assign free_slots = CNT_W'(DEPTH) - count_q;
    assign full       = free_slots < CNT_W'(NUM_CH);

    // Valid channels are packed into consecutive slots in ascending channel order.
    always_comb begin
        n_enq = '0;
        we    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            slot_idx[k] = wr_ptr_q + n_enq[PTR_W-1:0];
            if (commit_en_i && commit_valid_i[k]) begin
                we[k] = !full;
                n_enq = n_enq + CNT_W'(1);
            end
        end
    end

    assign accept     = !full && (n_enq != '0);
    assign head_valid = (count_q != '0) && !halted;
    assign pop        = head_valid && out_ready_i;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + n_enq[PTR_W-1:0];
        end
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            instr_cnt_d = instr_cnt_q + 64'd1;
        end
        count_d = count_q + (accept ? n_enq : CNT_W'(0)) - CNT_W'(pop);
        if (full && (n_enq != '0)) begin
            overflow_d = 1'b1;
        end
        if (!halted) begin
            cycle_cnt_d = cycle_cnt_q + 64'd1;
        end
    end

`ifdef DIFFTEST_TRAP_EN
    always_comb begin
        trap_valid_d = trap_valid_q;
        trap_code_d  = trap_code_q;
        trap_pc_d    = trap_pc_q;
        if (pop && (mem_instr_q[rd_ptr_q] == TRAP_INSTR)) begin
            trap_valid_d = 1'b1;
            trap_code_d  = mem_wdata_q[rd_ptr_q][7:0];
            trap_pc_d    = mem_pc_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            trap_valid_q <= 1'b0;
            trap_code_q  <= '0;
            trap_pc_q    <= '0;
        end else begin
            trap_valid_q <= trap_valid_d;
            trap_code_q  <= trap_code_d;
            trap_pc_q    <= trap_pc_d;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clock) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (we[k]) begin
                mem_pc_q[slot_idx[k]]    <= commit_pc_i[k*PC_W +: PC_W];
                mem_instr_q[slot_idx[k]] <= commit_instr_i[k*INSTR_W +: INSTR_W];
                mem_wreg_q[slot_idx[k]]  <= commit_wreg_i[k];
                mem_waddr_q[slot_idx[k]] <= commit_waddr_i[k*REG_AW +: REG_AW];
                mem_wdata_q[slot_idx[k]] <= commit_wdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign full_o      = full;
    assign overflow_o  = overflow_q;
    assign out_valid_o = head_valid;
    assign out_pc_o    = mem_pc_q[rd_ptr_q];
    assign out_instr_o = mem_instr_q[rd_ptr_q];
    assign out_wdest_o = mem_waddr_q[rd_ptr_q];
    assign out_wdata_o = mem_wdata_q[rd_ptr_q];
    assign out_wen_o   = mem_wreg_q[rd_ptr_q] && (mem_waddr_q[rd_ptr_q] != '0);
    assign out_index_o = instr_cnt_q[7:0];
    assign cycle_cnt_o = cycle_cnt_q;
    assign instr_cnt_o = instr_cnt_q;

endmodule
